// File: rtl/fifo_upsize_pkg.sv
// rtl/fifo_upsize_pkg.sv - shared widths, defaults and lane-mask helper for the FWFT upsizer
package fifo_upsize_pkg;

  localparam int DEF_RATIO   = 4;
  localparam int DEF_TIMEOUT = 255;
  localparam int MAX_LANES   = 32;
  localparam int CNT_W       = $clog2(DEF_RATIO);
  localparam int TMR_W       = $clog2(DEF_TIMEOUT + 1);

  // Mask with lanes 0..cnt-1 set, limited to ratio lanes.
  function automatic logic [MAX_LANES-1:0] lane_mask(input int unsigned cnt, input int unsigned ratio);
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      m[i] = (i < cnt) && (i < ratio);
    end
    return m;
  endfunction

endpackage

// File: rtl/upsize_flush_timer.sv
// rtl/upsize_flush_timer.sv - saturating idle counter that flags a partial-word flush timeout
module upsize_flush_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic count_en,
  input  logic clear,
  output logic expired
);

  localparam int            TW    = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

  logic [TW-1:0] tmr;

  // Holds at LIMIT while the flush is blocked by a held output word.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      tmr <= '0;
    end else if (count_en && (tmr != LIMIT)) begin
      tmr <= tmr + TW'(1);
    end
  end

  assign expired = (tmr == LIMIT);

endmodule

// File: rtl/fifo_fwft_upsizer.sv
// rtl/fifo_fwft_upsizer.sv - packs RATIO FWFT FIFO words into one wide valid/ready word
// Optional idle flush of partial words: FIFO_FWFT_UPSIZER_FLUSH_EN
module fifo_fwft_upsizer
  import fifo_upsize_pkg::*;
#(
  parameter int IN_WIDTH = 8,
  parameter int RATIO    = DEF_RATIO,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_empty,
  output logic                      in_rd_en,
  output logic [IN_WIDTH*RATIO-1:0] out_data,
  output logic [RATIO-1:0]          out_keep,
  output logic                      out_valid,
  input  logic                      out_ready
);

  localparam int            CW    = $clog2(RATIO);
  localparam int            OUT_W = IN_WIDTH * RATIO;
  localparam logic [CW-1:0] LAST  = CW'(RATIO - 1);

  if (RATIO < 2 || RATIO > MAX_LANES) begin : g_bad_ratio
    $error("fifo_fwft_upsizer: RATIO out of range");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("fifo_fwft_upsizer: TIMEOUT must be at least 1");
  end

  logic [CW-1:0]    cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] data_q;
  logic [RATIO-1:0] keep_q;
  logic             valid_q;
  logic             pop;
  logic             last_pop;
  logic             flush;
  logic [RATIO-1:0] flush_keep;

  // The final lane may only be popped when the output register can take the word.
  assign pop      = !rst && !in_empty && ((cnt != LAST) || !valid_q || out_ready);
  assign last_pop = pop && (cnt == LAST);
  assign in_rd_en = pop;

`ifdef FIFO_FWFT_UPSIZER_FLUSH_EN
  logic expired;

  upsize_flush_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_flush_timer (
    .clk      (clk),
    .rst      (rst),
    .count_en ((cnt != '0) && !pop),
    .clear    (pop || flush),
    .expired  (expired)
  );

  assign flush      = expired && !pop && (cnt != '0) && (!valid_q || out_ready);
  assign flush_keep = RATIO'(lane_mask(32'(cnt), RATIO));
`else
  assign flush      = 1'b0;
  assign flush_keep = '1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      acc     <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      valid_q <= 1'b0;
    end else if (last_pop) begin
      data_q  <= {in_data, acc[OUT_W-IN_WIDTH-1:0]};
      keep_q  <= '1;
      valid_q <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
    end else if (flush) begin
      data_q  <= acc;
      keep_q  <= flush_keep;
      valid_q <= 1'b1;
      cnt     <= '0;
      acc     <= '0;
    end else begin
      if (pop) begin
        acc[cnt*IN_WIDTH +: IN_WIDTH] <= in_data;
        cnt                           <= cnt + CW'(1);
      end
      if (valid_q && out_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = !rst && valid_q;
  assign out_data  = rst ? '0 : data_q;
  assign out_keep  = rst ? '0 : keep_q;

endmodule

// File: tb/tb_fifo_fwft_upsizer.sv
// tb/tb_fifo_fwft_upsizer.sv - directed bench with a lane-queue reference model for fifo_fwft_upsizer
module tb_fifo_fwft_upsizer;

  localparam int W   = 8;
  localparam int R   = 4;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_empty = 1'b1;
  logic          in_rd_en;
  logic [31:0]   out_data;
  logic [3:0]    out_keep;
  logic          out_valid;
  logic          out_ready = 1'b0;

  int checks = 0;
  int failures = 0;

  logic [7:0] src[$];
  bit         do_pop = 1'b0;

  logic [7:0]  m_lanes[$];
  bit          m_valid = 1'b0;
  logic [31:0] m_data = '0;
  logic [3:0]  m_keep = '0;
  int          m_idle = 0;

  always #5 clk = ~clk;

  fifo_fwft_upsizer #(
    .IN_WIDTH(W),
    .RATIO   (R),
    .TIMEOUT (TMO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_empty (in_empty),
    .in_rd_en (in_rd_en),
    .out_data (out_data),
    .out_keep (out_keep),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_lanes();
    logic [31:0] d;
    d = '0;
    for (int i = 0; i < m_lanes.size(); i++) d[i*8 +: 8] = m_lanes[i];
    return d;
  endfunction

  // FWFT source: head of the queue is presented; popped after an accepted rd_en.
  always @(posedge clk) begin
    #2;
    if (do_pop && src.size() > 0) void'(src.pop_front());
    in_empty = (src.size() == 0);
    in_data  = (src.size() > 0) ? src[0] : 8'h00;
  end

  always @(negedge clk) begin : compare
    bit exp_pop;
    int n;
    if (rst) begin
      chk("rst_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_rd_en", {31'd0, in_rd_en}, 32'd0);
      chk("rst_data", out_data, 32'd0);
      chk("rst_keep", {28'd0, out_keep}, 32'd0);
      m_lanes.delete();
      m_valid = 1'b0;
      m_idle  = 0;
      do_pop  = 1'b0;
    end else begin
      chk("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
      if (m_valid) begin
        chk("out_data", out_data, m_data);
        chk("out_keep", {28'd0, out_keep}, {28'd0, m_keep});
      end
      n = m_lanes.size();
      exp_pop = !in_empty && (n < R - 1 || !m_valid || out_ready);
      chk("in_rd_en", {31'd0, in_rd_en}, {31'd0, exp_pop});
      do_pop = in_rd_en;
      if (exp_pop) begin
        m_lanes.push_back(in_data);
        m_idle = 0;
        if (m_lanes.size() == R) begin
          m_data  = pack_lanes();
          m_keep  = 4'hF;
          m_valid = 1'b1;
          m_lanes.delete();
        end else if (m_valid && out_ready) begin
          m_valid = 1'b0;
        end
      end
`ifdef FIFO_FWFT_UPSIZER_FLUSH_EN
      else if (n > 0 && m_idle == TMO && (!m_valid || out_ready)) begin
        m_data  = pack_lanes();
        m_keep  = 4'((1 << n) - 1);
        m_valid = 1'b1;
        m_lanes.delete();
        m_idle  = 0;
      end
`endif
      else begin
        if (m_valid && out_ready) m_valid = 1'b0;
        if (n > 0 && m_idle < TMO) m_idle++;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max, output int idx);
    idx = -1;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) begin
        idx = i;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int rd_cnt;
    int v_cnt;
    int first;
    int last;

    rst = 1'b1;
    step(3);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_data", out_data, 32'd0);
    rst = 1'b0;
    step(1);

    // 1: four bytes back-to-back, word one cycle after last pop
    out_ready = 1'b1;
    push4(8'h11, 8'h22, 8'h33, 8'h44);
    wait_valid(10, idx);
    chk("t1_latency", idx, 32'd4);
    chk("t1_data", out_data, 32'h44332211);
    chk("t1_keep", {28'd0, out_keep}, 32'hF);
    @(negedge clk);
    chk("t1_one_cycle", {31'd0, out_valid}, 32'd0);
    step(1);

    // 2: twelve bytes streamed with no bubbles
    for (int i = 0; i < 12; i++) src.push_back(8'(i + 1));
    rd_cnt = 0; v_cnt = 0; first = -1; last = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (in_rd_en) begin
        rd_cnt++;
        if (first < 0) first = i;
        last = i;
      end
      if (out_valid) v_cnt++;
    end
    chk("t2_pops", rd_cnt, 32'd12);
    chk("t2_contiguous", last - first, 32'd11);
    chk("t2_words", v_cnt, 32'd3);
    step(1);

    // 3: held output stalls the final lane
    out_ready = 1'b0;
    push4(8'hA0, 8'hA1, 8'hA2, 8'hA3);
    wait_valid(10, idx);
    chk("t3_word_a", out_data, 32'hA3A2A1A0);
    step(1);
    push4(8'hB0, 8'hB1, 8'hB2, 8'hB3);
    rd_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (in_rd_en) rd_cnt++;
    end
    chk("t3_pops", rd_cnt, 32'd3);
    chk("t3_stalled", {31'd0, in_rd_en}, 32'd0);
    chk("t3_held_data", out_data, 32'hA3A2A1A0);
    step(1);

    // 4: handshake and completion in the same cycle
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_pop_with_hs", {31'd0, in_rd_en}, 32'd1);
    @(negedge clk);
    chk("t4_valid_kept", {31'd0, out_valid}, 32'd1);
    chk("t4_word_b", out_data, 32'hB3B2B1B0);
    @(negedge clk);
    chk("t4_drained", {31'd0, out_valid}, 32'd0);
    step(1);

    // 5: partial word followed by idle
    src.push_back(8'hAA);
    src.push_back(8'hBB);
    wait_valid(20, idx);
`ifdef FIFO_FWFT_UPSIZER_FLUSH_EN
    chk("t5_flush_time", idx, 32'd11);
    chk("t5_flush_data", out_data, 32'h0000BBAA);
    chk("t5_flush_keep", {28'd0, out_keep}, 32'h3);
    step(1);
`else
    chk("t5_no_flush", idx, 32'hFFFF_FFFF);
    step(1);
    src.push_back(8'hCC);
    src.push_back(8'hDD);
    wait_valid(10, idx);
    chk("t5_late_data", out_data, 32'hDDCCBBAA);
    chk("t5_late_keep", {28'd0, out_keep}, 32'hF);
    step(1);
`endif
    step(2);

    // 6: reset with a partial and a held word discards both
    out_ready = 1'b0;
    push4(8'h51, 8'h52, 8'h53, 8'h54);
    wait_valid(10, idx);
    step(1);
    src.push_back(8'h61);
    src.push_back(8'h62);
    step(4);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", {31'd0, out_valid}, 32'd0);
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_valid_cleared", {31'd0, out_valid}, 32'd0);
    step(1);
    out_ready = 1'b1;
    push4(8'h71, 8'h72, 8'h73, 8'h74);
    wait_valid(10, idx);
    chk("t6_found", {31'd0, idx >= 0}, 32'd1);
    chk("t6_data", out_data, 32'h74737271);
    chk("t6_keep", {28'd0, out_keep}, 32'hF);
    step(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic push4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    src.push_back(a);
    src.push_back(b);
    src.push_back(c);
    src.push_back(d);
  endtask

endmodule
